// File: rtl/ud6_monitor.sv
// ud6_monitor: checker/decoder for a mod-6 up/down counter (q, m sampled every clk)
//   clk      rising-edge clock shared with the counter
//   reset    asynchronous active-low reset
//   m, q     counter direction (1 = up) and state (legal 0..5)
//   onehot   registered one-hot decode of sampled q, all-0 for illegal codes
//   carry    pulse on up-wrap 5->0, borrow pulse on down-wrap 0->5
//   dir_chg  pulse when m differs from the previous tracked sample
//   wrap_cnt saturating count of carry+borrow events
//   err      illegal code or illegal step; latched (STICKY_ERR=1) or pulsed with resync (0)
module ud6_monitor #(
  parameter int WRAP_W = 8,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m,
  input  logic [2:0]        q,
  output logic [5:0]        onehot,
  output logic              carry,
  output logic              borrow,
  output logic              dir_chg,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t state, state_n;
  logic [2:0] prev_q, prev_q_n, exp_q;
  logic prev_m, prev_m_n, legal, carry_n, borrow_n, dir_chg_n, err_n;
  assign legal = q < 3'd6;
  // the step is judged against the direction held on the previous sample
  assign exp_q = prev_m ? (prev_q == 3'd5 ? 3'd0 : prev_q + 3'd1)
                        : (prev_q == 3'd0 ? 3'd5 : prev_q - 3'd1);
  always_comb begin
    state_n = state;
    prev_q_n = prev_q;
    prev_m_n = prev_m;
    carry_n = 1'b0;
    borrow_n = 1'b0;
    dir_chg_n = 1'b0;
    err_n = 1'b0;
    case (state)
      INIT: begin
        prev_q_n = q;
        prev_m_n = m;
        err_n = !legal;
        state_n = legal ? TRACK : (STICKY_ERR ? FAULT : INIT);
      end
      TRACK:
        if (!legal || q != exp_q) begin
          err_n = 1'b1;
          state_n = STICKY_ERR ? FAULT : INIT;
        end else begin
          carry_n = prev_m && prev_q == 3'd5 && q == 3'd0;
          borrow_n = !prev_m && prev_q == 3'd0 && q == 3'd5;
          dir_chg_n = m != prev_m;
          prev_q_n = q;
          prev_m_n = m;
        end
      FAULT: err_n = 1'b1;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      prev_q <= '0;
      prev_m <= 1'b0;
      onehot <= '0;
      carry <= 1'b0;
      borrow <= 1'b0;
      dir_chg <= 1'b0;
      wrap_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      prev_q <= prev_q_n;
      prev_m <= prev_m_n;
      onehot <= legal ? 6'(6'd1 << q) : 6'd0;
      carry <= carry_n;
      borrow <= borrow_n;
      dir_chg <= dir_chg_n;
      wrap_cnt <= ((carry_n || borrow_n) && !(&wrap_cnt)) ? wrap_cnt + WRAP_W'(1) : wrap_cnt;
      err <= err_n;
    end
endmodule

// File: tb/tb_ud6_monitor.sv
// tb_ud6_monitor: scoreboard bench for ud6_monitor (sticky/W8, non-sticky, W2 instances)
module tb_ud6_monitor;
  logic clk = 1'b0;
  logic reset, m;
  logic [2:0] q;
  logic [5:0] onehot, onehot0, onehot2;
  logic carry, borrow, dir_chg, err;
  logic carry0, borrow0, dir_chg0, err0;
  logic carry2, borrow2, dir_chg2, err2;
  logic [7:0] wrap_cnt, wrap_cnt0;
  logic [1:0] wrap_cnt2;
  int tests = 0, fails = 0;

  typedef struct {
    logic [2:0] q;
    logic c, b, d, e;
    logic [7:0] w;
    logic e0;
    logic [1:0] w2;
  } exp_t;
  exp_t sb[$];

  ud6_monitor dut (.clk(clk), .reset(reset), .m(m), .q(q), .onehot(onehot), .carry(carry),
    .borrow(borrow), .dir_chg(dir_chg), .wrap_cnt(wrap_cnt), .err(err));
  ud6_monitor #(.WRAP_W(8), .STICKY_ERR(1'b0)) dut0 (.clk(clk), .reset(reset), .m(m), .q(q),
    .onehot(onehot0), .carry(carry0), .borrow(borrow0), .dir_chg(dir_chg0),
    .wrap_cnt(wrap_cnt0), .err(err0));
  ud6_monitor #(.WRAP_W(2), .STICKY_ERR(1'b1)) dut2 (.clk(clk), .reset(reset), .m(m), .q(q),
    .onehot(onehot2), .carry(carry2), .borrow(borrow2), .dir_chg(dir_chg2),
    .wrap_cnt(wrap_cnt2), .err(err2));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  task automatic step(input logic [2:0] qv, input logic mv, input logic c, input logic b,
                      input logic d, input logic e, input logic [7:0] w, input logic e0,
                      input logic [1:0] w2);
    q = qv;
    m = mv;
    sb.push_back('{qv, c, b, d, e, w, e0, w2});
    @(negedge clk);
  endtask

  task automatic rst_pulse(input string n);
    reset = 1'b0;
    #1;
    chk({n, "_onehot"}, 8'(onehot), 8'h00);
    chk({n, "_flags"}, 8'({carry, borrow, dir_chg, err}), 8'h00);
    chk({n, "_wrap"}, wrap_cnt, 8'h00);
    chk({n, "_err0"}, 8'(err0), 8'h00);
    chk({n, "_wrap2"}, 8'(wrap_cnt2), 8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t x;
    logic [7:0] oh;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        oh = (x.q < 3'd6) ? 8'(8'd1 << x.q) : 8'h00;
        chk("onehot", 8'(onehot), oh);
        chk("carry", 8'(carry), 8'(x.c));
        chk("borrow", 8'(borrow), 8'(x.b));
        chk("dir_chg", 8'(dir_chg), 8'(x.d));
        chk("err", 8'(err), 8'(x.e));
        chk("wrap_cnt", wrap_cnt, x.w);
        chk("err_nonsticky", 8'(err0), 8'(x.e0));
        chk("wrap_cnt_w2", 8'(wrap_cnt2), 8'(x.w2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] qq;
    int wk;
    reset = 1'b0;
    q = 3'd0;
    m = 1'b0;
    @(negedge clk);
    rst_pulse("por");
    // up walk with repeated carries; the W2 instance saturates at 3
    step(3'd0, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    for (int k = 1; k <= 5; k++)
      for (int s = 1; s <= 6; s++) begin
        qq = 3'(s % 6);
        wk = (qq == 3'd0) ? k : k - 1;
        step(qq, 1'b1, qq == 3'd0, 0, 0, 0, 8'(wk), 0, 2'(wk > 3 ? 3 : wk));
      end
    step(3'd1, 1'b1, 0, 0, 0, 0, 8'd5, 0, 2'd3);
    step(3'd2, 1'b1, 0, 0, 0, 0, 8'd5, 0, 2'd3);
    rst_pulse("midrun");
    // down wrap 0->5
    step(3'd0, 1'b0, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd5, 1'b0, 0, 1, 0, 0, 8'd1, 0, 2'd1);
    step(3'd4, 1'b0, 0, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd3, 1'b0, 0, 0, 0, 0, 8'd1, 0, 2'd1);
    rst_pulse("r2");
    // direction change at q=3
    step(3'd0, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd1, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd2, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd3, 1'b0, 0, 0, 1, 0, 8'd0, 0, 2'd0);
    step(3'd2, 1'b0, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd1, 1'b0, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    rst_pulse("r3");
    // illegal code 7 after one wrap: sticky freezes, non-sticky resyncs
    step(3'd4, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd5, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd0, 1'b1, 1, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd1, 1'b1, 0, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd7, 1'b1, 0, 0, 0, 1, 8'd1, 1, 2'd1);
    step(3'd2, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    step(3'd3, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    step(3'd4, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    step(3'd5, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    step(3'd0, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    rst_pulse("r4");
    // illegal skip 2->4
    step(3'd5, 1'b1, 0, 0, 0, 0, 8'd0, 0, 2'd0);
    step(3'd0, 1'b1, 1, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd1, 1'b1, 0, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd2, 1'b1, 0, 0, 0, 0, 8'd1, 0, 2'd1);
    step(3'd4, 1'b1, 0, 0, 0, 1, 8'd1, 1, 2'd1);
    step(3'd5, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    step(3'd0, 1'b1, 0, 0, 0, 1, 8'd1, 0, 2'd1);
    rst_pulse("r5");
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
